// File: rtl/reg_mem_pkg.sv
// Shared definitions for the register/memory command controller.
//   - default widths for DATA_W / ADDR_W / REG_N
//   - command opcodes (OP_ST_IMM .. OP_RD_MEM)
//   - controller FSM state encoding
package reg_mem_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned REG_N_DEF  = 8;

  localparam logic [1:0] OP_ST_IMM = 2'd0;
  localparam logic [1:0] OP_ST_REG = 2'd1;
  localparam logic [1:0] OP_LD_REG = 2'd2;
  localparam logic [1:0] OP_RD_MEM = 2'd3;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StWait = 2'd2,
    StDone = 2'd3
  } state_e;

  // Both load-type opcodes have bit 1 set.
  function automatic logic op_is_read(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/reg_bank.sv
// Register bank: REG_N x DATA_W, one synchronous write port, two combinational
// read ports, asynchronous clear.
//   clk, rst_n          : clock, async active-low clear of all entries
//   i_we/i_waddr/i_wdata: write port (takes effect on posedge)
//   i_raddr_a/o_rdata_a : combinational read port A
//   i_raddr_b/o_rdata_b : combinational read port B
module reg_bank #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_N  = 8,
  parameter int unsigned IDX_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [IDX_W-1:0]  i_raddr_a,
  output logic [DATA_W-1:0] o_rdata_a,
  input  logic [IDX_W-1:0]  i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_b
);

  logic [DATA_W-1:0] r_regs [REG_N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_N; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_regs[i_raddr_a];
  assign o_rdata_b = r_regs[i_raddr_b];

endmodule

// File: rtl/reg_mem_ctrl.sv
// Command controller moving words between an immediate, a register bank and an
// external synchronous memory.
//   cmd_*     : command handshake (accepted on cmd_valid && cmd_ready)
//   rsp_*     : one-cycle completion pulse with opcode and data word
//   mem_*     : external memory port; mem_dout valid MEM_LAT cycles after read
//   dbg_sel/dbg_data : combinational register-bank peek
//   busy      : controller not idle
module reg_mem_ctrl
  import reg_mem_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned REG_N   = REG_N_DEF,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [2:0]        cmd_reg,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [1:0]        rsp_op,
  output logic [DATA_W-1:0] rsp_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  input  logic [2:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data,
  output logic              busy
);

  localparam int unsigned    CntW  = 2;
  localparam logic [CntW-1:0] LatM1 = CntW'(MEM_LAT - 1);

  state_e            r_state, w_state_d;
  logic [1:0]        r_op;
  logic [2:0]        r_reg;
  logic [DATA_W-1:0] r_word;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_din;
  logic [CntW-1:0]   r_cnt;

  logic              w_accept;
  logic              w_last_wait;
  logic [DATA_W-1:0] w_reg_rd;
  logic [DATA_W-1:0] w_st_word;
  logic              w_reg_we;

  assign w_accept    = cmd_valid && (r_state == StIdle);
  assign w_last_wait = (r_state == StWait) && (r_cnt == '0);
  assign w_st_word   = (cmd_op == OP_ST_IMM) ? cmd_data : w_reg_rd;
  assign w_reg_we    = w_last_wait && (r_op == OP_LD_REG);

  reg_bank #(
    .DATA_W (DATA_W),
    .REG_N  (REG_N),
    .IDX_W  (3)
  ) u_reg_bank (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_we      (w_reg_we),
    .i_waddr   (r_reg),
    .i_wdata   (mem_dout),
    .i_raddr_a (cmd_reg),
    .o_rdata_a (w_reg_rd),
    .i_raddr_b (dbg_sel),
    .o_rdata_b (dbg_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    rsp_valid = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    unique case (r_state)
      StIdle: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) w_state_d = StExec;
      end
      StExec: begin
        mem_en    = 1'b1;
        mem_we    = !op_is_read(r_op);
        w_state_d = op_is_read(r_op) ? StWait : StDone;
      end
      StWait: begin
        if (r_cnt == '0) w_state_d = StDone;
      end
      StDone: begin
        rsp_valid = 1'b1;
        w_state_d = StIdle;
      end
    endcase
  end

  // mem_addr/mem_din are loaded at accept so they are valid throughout EXEC
  // and simply hold afterwards; reads leave mem_din untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op       <= '0;
      r_reg      <= '0;
      r_word     <= '0;
      r_mem_addr <= '0;
      r_mem_din  <= '0;
      r_cnt      <= '0;
    end else begin
      if (w_accept) begin
        r_op       <= cmd_op;
        r_reg      <= cmd_reg;
        r_mem_addr <= cmd_addr;
        if (!op_is_read(cmd_op)) begin
          r_word    <= w_st_word;
          r_mem_din <= w_st_word;
        end
      end
      if (r_state == StExec) begin
        r_cnt <= LatM1;
      end else if ((r_state == StWait) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_last_wait) begin
        r_word <= mem_dout;
      end
    end
  end

  assign rsp_op   = r_op;
  assign rsp_data = r_word;
  assign mem_addr = r_mem_addr;
  assign mem_din  = r_mem_din;

endmodule

// File: tb/tb_reg_mem_ctrl.sv
// Bench for reg_mem_ctrl: two instances (MEM_LAT=1 and MEM_LAT=2), each with
// its own 16x32 memory model, checked against a per-instance reference model.
module tb_reg_mem_ctrl;
  import reg_mem_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;
  localparam int unsigned NI = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n     [NI];
  logic          cmd_valid [NI];
  logic          cmd_ready [NI];
  logic [1:0]    cmd_op    [NI];
  logic [2:0]    cmd_reg   [NI];
  logic [AW-1:0] cmd_addr  [NI];
  logic [DW-1:0] cmd_data  [NI];
  logic          rsp_valid [NI];
  logic [1:0]    rsp_op    [NI];
  logic [DW-1:0] rsp_data  [NI];
  logic          mem_en    [NI];
  logic          mem_we    [NI];
  logic [AW-1:0] mem_addr  [NI];
  logic [DW-1:0] mem_din   [NI];
  logic [DW-1:0] mem_dout  [NI];
  logic [2:0]    dbg_sel   [NI];
  logic [DW-1:0] dbg_data  [NI];
  logic          busy      [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    reg_mem_ctrl #(
      .DATA_W  (DW),
      .ADDR_W  (AW),
      .REG_N   (8),
      .MEM_LAT (g + 1)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n[g]),
      .cmd_valid (cmd_valid[g]),
      .cmd_ready (cmd_ready[g]),
      .cmd_op    (cmd_op[g]),
      .cmd_reg   (cmd_reg[g]),
      .cmd_addr  (cmd_addr[g]),
      .cmd_data  (cmd_data[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_op    (rsp_op[g]),
      .rsp_data  (rsp_data[g]),
      .mem_en    (mem_en[g]),
      .mem_we    (mem_we[g]),
      .mem_addr  (mem_addr[g]),
      .mem_din   (mem_din[g]),
      .mem_dout  (mem_dout[g]),
      .dbg_sel   (dbg_sel[g]),
      .dbg_data  (dbg_data[g]),
      .busy      (busy[g])
    );
  end

  function automatic logic [DW-1:0] init_word(input int a);
    return 32'hA5A5_0000 | 32'(a);
  endfunction

  // Memory model: instance k has read latency k+1; dout is garbage whenever
  // no read data is due, so a mistimed sample shows up as a wrong word.
  logic [DW-1:0] mem_m  [NI][16];
  logic [DW-1:0] pipe_q [NI];
  logic          pipe_v [NI];
  logic          mem_init_done = 1'b0;

  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int k = 0; k < NI; k++) begin
        for (int a = 0; a < 16; a++) mem_m[k][a] <= init_word(a);
        mem_dout[k] <= $urandom;
        pipe_v[k]   <= 1'b0;
        pipe_q[k]   <= '0;
      end
      mem_init_done <= 1'b1;
    end else begin
      for (int k = 0; k < NI; k++) begin
        if (mem_en[k] && mem_we[k]) mem_m[k][mem_addr[k]] <= mem_din[k];
        pipe_v[k] <= mem_en[k] && !mem_we[k];
        pipe_q[k] <= mem_m[k][mem_addr[k]];
        if (k == 0) begin
          mem_dout[k] <= (mem_en[k] && !mem_we[k]) ? mem_m[k][mem_addr[k]] : $urandom;
        end else begin
          mem_dout[k] <= pipe_v[k] ? pipe_q[k] : $urandom;
        end
      end
    end
  end

  // Reference model state.
  logic [DW-1:0] ref_mem  [NI][16];
  logic [DW-1:0] ref_regs [NI][8];
  logic [DW-1:0] last_din [NI];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic scramble(input int k, input bit hold);
    cmd_valid[k] = hold;
    cmd_op[k]    = 2'($urandom_range(0, 3));
    cmd_reg[k]   = 3'($urandom_range(0, 7));
    cmd_addr[k]  = 4'($urandom_range(0, 15));
    cmd_data[k]  = $urandom;
  endtask

  // Wipes the reference registers; memory contents survive reset.
  task automatic do_reset(input int k);
    rst_n[k] = 1'b0;
    #1;
    check_eq($sformatf("i%0d rst busy", k), 32'(busy[k]), 32'd0);
    check_eq($sformatf("i%0d rst rsp_valid", k), 32'(rsp_valid[k]), 32'd0);
    check_eq($sformatf("i%0d rst mem_en_we", k), 32'({mem_en[k], mem_we[k]}), 32'd0);
    check_eq($sformatf("i%0d rst mem_addr", k), 32'(mem_addr[k]), 32'd0);
    check_eq($sformatf("i%0d rst mem_din", k), mem_din[k], 32'd0);
    check_eq($sformatf("i%0d rst rsp_data", k), rsp_data[k], 32'd0);
    check_eq($sformatf("i%0d rst dbg_data", k), dbg_data[k], 32'd0);
    for (int i = 0; i < 8; i++) ref_regs[k][i] = '0;
    last_din[k] = '0;
    repeat (2) begin
      @(posedge clk); #1;
      check_eq($sformatf("i%0d rst hold rsp_valid", k), 32'(rsp_valid[k]), 32'd0);
    end
    @(negedge clk);
    rst_n[k] = 1'b1;
    @(posedge clk); #1;
    check_eq($sformatf("i%0d post-rst ready/busy", k), 32'({cmd_ready[k], busy[k]}), 32'b10);
  endtask

  // Issue one command and check its whole life. Entered and left at #1 after
  // a posedge; on return the controller is idle. With hold=1 cmd_valid stays
  // high with junk fields, so the caller must issue the next command at once.
  task automatic run_cmd(input int k, input logic [1:0] op, input logic [2:0] rg,
                         input logic [AW-1:0] addr, input logic [DW-1:0] data, input bit hold);
    int            lat;
    int            guard;
    bit            is_rd;
    logic [DW-1:0] word;
    is_rd = (op == OP_LD_REG) || (op == OP_RD_MEM);
    lat   = is_rd ? 2 + k + 1 : 2;
    case (op)
      OP_ST_IMM: word = data;
      OP_ST_REG: word = ref_regs[k][rg];
      default:   word = ref_mem[k][addr];
    endcase
    cmd_valid[k] = 1'b1;
    cmd_op[k]    = op;
    cmd_reg[k]   = rg;
    cmd_addr[k]  = addr;
    cmd_data[k]  = data;
    dbg_sel[k]   = (op == OP_LD_REG) ? rg : 3'($urandom_range(0, 7));
    guard = 0;
    while (!cmd_ready[k] && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check_eq($sformatf("i%0d ready before accept", k), 32'(cmd_ready[k]), 32'd1);
    @(posedge clk); #1;
    for (int c = 1; c <= lat + 1; c++) begin
      if (c == 1) begin
        check_eq($sformatf("i%0d exec en/we", k), 32'({mem_en[k], mem_we[k]}),
                 32'({1'b1, !is_rd}));
        check_eq($sformatf("i%0d exec mem_addr", k), 32'(mem_addr[k]), 32'(addr));
        check_eq($sformatf("i%0d exec mem_din", k), mem_din[k], is_rd ? last_din[k] : word);
      end else begin
        check_eq($sformatf("i%0d c%0d en/we idle", k, c), 32'({mem_en[k], mem_we[k]}), 32'd0);
      end
      if (c < lat) begin
        check_eq($sformatf("i%0d c%0d valid/ready/busy", k, c),
                 32'({rsp_valid[k], cmd_ready[k], busy[k]}), 32'b001);
      end else if (c == lat) begin
        if (!is_rd) begin
          ref_mem[k][addr] = word;
          last_din[k]      = word;
        end
        if (op == OP_LD_REG) ref_regs[k][rg] = word;
        check_eq($sformatf("i%0d done valid/ready/busy", k),
                 32'({rsp_valid[k], cmd_ready[k], busy[k]}), 32'b101);
        check_eq($sformatf("i%0d rsp_op", k), 32'(rsp_op[k]), 32'(op));
        check_eq($sformatf("i%0d rsp_data op%0d", k, op), rsp_data[k], word);
        check_eq($sformatf("i%0d done mem_addr hold", k), 32'(mem_addr[k]), 32'(addr));
        check_eq($sformatf("i%0d dbg_data sel%0d", k, dbg_sel[k]), dbg_data[k],
                 ref_regs[k][dbg_sel[k]]);
        if (!is_rd) begin
          check_eq($sformatf("i%0d mem[%0d]", k, addr), mem_m[k][addr], ref_mem[k][addr]);
        end
      end else begin
        check_eq($sformatf("i%0d after valid/ready/busy", k),
                 32'({rsp_valid[k], cmd_ready[k], busy[k]}), 32'b010);
      end
      if (c <= lat) begin
        scramble(k, hold);
        @(posedge clk); #1;
      end
    end
  endtask

  // LD_REG interrupted by reset while in WAIT: no response, no register write.
  task automatic abort_ld(input int k, input logic [2:0] rg);
    cmd_valid[k] = 1'b1;
    cmd_op[k]    = OP_LD_REG;
    cmd_reg[k]   = rg;
    cmd_addr[k]  = 4'd1;
    dbg_sel[k]   = rg;
    @(posedge clk); #1;
    cmd_valid[k] = 1'b0;
    @(posedge clk); #1;
    check_eq($sformatf("i%0d abort pre busy", k), 32'({busy[k], rsp_valid[k]}), 32'b10);
    do_reset(k);
    check_eq($sformatf("i%0d abort reg%0d", k, rg), dbg_data[k], 32'd0);
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      rst_n[k]     = 1'b0;
      cmd_valid[k] = 1'b0;
      cmd_op[k]    = '0;
      cmd_reg[k]   = '0;
      cmd_addr[k]  = '0;
      cmd_data[k]  = '0;
      dbg_sel[k]   = '0;
      last_din[k]  = '0;
      for (int a = 0; a < 16; a++) ref_mem[k][a] = init_word(a);
      for (int i = 0; i < 8; i++) ref_regs[k][i] = '0;
    end
    #2;
    for (int k = 0; k < NI; k++) do_reset(k);

    for (int k = 0; k < NI; k++) begin
      run_cmd(k, OP_ST_IMM, 3'd0, 4'd1, 32'd10, 1'b0);
      run_cmd(k, OP_LD_REG, 3'd4, 4'd1, 32'd0, 1'b0);
      dbg_sel[k] = 3'd4;
      #1;
      check_eq($sformatf("i%0d dbg reg4", k), dbg_data[k], 32'd10);
      run_cmd(k, OP_ST_REG, 3'd4, 4'd3, 32'd0, 1'b0);
      check_eq($sformatf("i%0d mem3 after st_reg", k), mem_m[k][3], 32'd10);
      run_cmd(k, OP_RD_MEM, 3'd0, 4'd3, 32'd0, 1'b0);

      // cmd_valid held with junk during busy; next command lands after DONE.
      run_cmd(k, OP_ST_IMM, 3'd0, 4'd5, 32'h1234_5678, 1'b1);
      run_cmd(k, OP_ST_IMM, 3'd0, 4'd6, 32'hCAFE_F00D, 1'b0);

      abort_ld(k, 3'd5);

      for (int i = 0; i < 30; i++) begin
        run_cmd(k, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                4'($urandom_range(0, 15)), $urandom,
                (i != 29) && ($urandom_range(0, 1) == 1));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
